// File: rtl/uart_tx.sv
// UART serial transmitter with its own 16x oversampling baud tick: start bit, LSB-first data,
// stop bit(s), then a one-cycle done pulse. Every frame is phase-aligned to its accepting edge.
module uart_tx #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16,
   parameter int unsigned DVSR    = 163
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tx_start,
   input  logic [DBIT-1:0] tx_bus,
   output logic            tx,
   output logic            tx_done_tick,
   output logic            tx_busy
);

   localparam int unsigned BW   = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam int unsigned SMAX = (SB_TICK > 16) ? SB_TICK : 16;
   localparam int unsigned SW   = $clog2(SMAX);
   localparam int unsigned NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [BW-1:0] BLast     = BW'(DVSR - 1);
   localparam logic [SW-1:0] SBitLast  = SW'(15);
   localparam logic [SW-1:0] SStopLast = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] NLast     = NW'(DBIT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [BW-1:0]     b_q, b_d;
   logic [SW-1:0]     s_q, s_d;
   logic [NW-1:0]     n_q, n_d;
   logic [DBIT-1:0]   d_q, d_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              s_tick;

   assign s_tick = (b_q == BLast);

   always_comb begin
      state_d = state_q;
      b_d     = s_tick ? '0 : b_q + 1'b1;
      s_d     = s_q;
      n_d     = n_q;
      d_d     = d_q;
      case (state_q)
         StIdle: begin
            if (tx_start) begin
               state_d = StStart;
               b_d     = '0;
               s_d     = '0;
               n_d     = '0;
               d_d     = tx_bus;
            end
         end
         StStart: begin
            if (s_tick) begin
               if (s_q == SBitLast) begin
                  s_d     = '0;
                  state_d = StData;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         StData: begin
            if (s_tick) begin
               if (s_q == SBitLast) begin
                  s_d = '0;
                  d_d = d_q >> 1;
                  if (n_q == NLast) state_d = StStop;
                  else              n_d     = n_q + 1'b1;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         default: begin
            if (s_tick) begin
               if (s_q == SStopLast) state_d = StIdle;
               else                  s_d     = s_q + 1'b1;
            end
         end
      endcase
   end

   // Outputs are registered from next-state values so they line up with the state they describe;
   // the done pulse is raised for the final tick cycle of the stop phase, still inside StStop.
   always_comb begin
      case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = d_d[0];
         default: tx_d = 1'b1;
      endcase
      done_d = (state_d == StStop) && (s_d == SStopLast) && (b_d == BLast);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         b_q     <= '0;
         s_q     <= '0;
         n_q     <= '0;
         d_q     <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         s_q     <= s_d;
         n_q     <= n_d;
         d_q     <= d_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign tx           = tx_q;
   assign tx_done_tick = done_q;
   assign tx_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, random frames against a per-cycle line model,
// and hand sequences for back-to-back, ignored requests, mid-frame reset and two stop bits.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [7:0] bus_a = '0, bus_b = '0;
   logic       tx_a, done_a, busy_a;
   logic       tx_b, done_b, busy_b;

   uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(2)) u_dut_a (
      .clk(clk), .reset(reset), .tx_start(start_a), .tx_bus(bus_a),
      .tx(tx_a), .tx_done_tick(done_a), .tx_busy(busy_a)
   );

   uart_tx #(.DBIT(8), .SB_TICK(32), .DVSR(1)) u_dut_b (
      .clk(clk), .reset(reset), .tx_start(start_b), .tx_bus(bus_b),
      .tx(tx_b), .tx_done_tick(done_b), .tx_busy(busy_b)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   logic sel   = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic [9:0] pat;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d);
      if (sel) begin
         start_b = v;
         bus_b   = d;
      end else begin
         start_a = v;
         bus_a   = d;
      end
   endtask

   function automatic logic cur_tx();
      return sel ? tx_b : tx_a;
   endfunction

   function automatic logic cur_busy();
      return sel ? busy_b : busy_a;
   endfunction

   function automatic logic cur_done();
      return sel ? done_b : done_a;
   endfunction

   // Expected line level c cycles after the accepting edge (c = 1 is the first start-bit cycle).
   function automatic logic model_tx(input logic [7:0] data, input int dvsr, input int c);
      int slot;
      slot = (c - 1) / (16 * dvsr);
      if (slot == 0) return 1'b0;
      if (slot <= 8) return data[slot-1];
      return 1'b1;
   endfunction

   // Sends one byte and checks it cycle by cycle. chain=1 returns in the cycle after the done
   // pulse so the next call can request immediately; glitch_c pulses tx_start mid-frame.
   task automatic frame(input string name, input logic [7:0] data, input int dvsr, input int sb,
                        input bit chain, input int glitch_c, input logic [7:0] glitch_d,
                        output logic [9:0] mid);
      int len, post, txe, busye, idlee, ndone, first;
      len   = 9 * 16 * dvsr + sb * dvsr;
      post  = chain ? 0 : 40;
      txe   = 0;
      busye = 0;
      idlee = 0;
      ndone = 0;
      first = -1;
      mid   = '0;
      drive(1'b1, data);
      tick();
      drive(1'b0, 8'($urandom));
      for (int c = 1; c <= len + post; c++) begin
         if (c <= len) begin
            if (cur_tx() !== model_tx(data, dvsr, c)) txe++;
            if (cur_busy() !== 1'b1) busye++;
         end else if (cur_tx() !== 1'b1 || cur_busy() !== 1'b0) begin
            idlee++;
         end
         if (cur_done() === 1'b1) begin
            ndone++;
            if (first < 0) first = c;
         end
         for (int k = 0; k < 9; k++)
            if (c == k * 16 * dvsr + 8 * dvsr) mid[k] = cur_tx();
         if (c == 9 * 16 * dvsr + (sb * dvsr) / 2) mid[9] = cur_tx();
         if (c == glitch_c) drive(1'b1, glitch_d);
         else if (c == glitch_c + 1) drive(1'b0, 8'($urandom));
         tick();
      end
      check({name, " tx_line"}, txe, 0);
      check({name, " busy"}, busye, 0);
      check({name, " done_count"}, ndone, 1);
      check({name, " done_cycle"}, first, len);
      if (!chain) check({name, " idle_after"}, idlee, 0);
   endtask

   initial begin
      vec_t       tbl[5];
      logic [9:0] mid;
      int         errs;
      logic [7:0] rd;

      tbl[0] = '{data: 8'hA5, pat: 10'b1101001010};
      tbl[1] = '{data: 8'h00, pat: 10'b1000000000};
      tbl[2] = '{data: 8'hFF, pat: 10'b1111111110};
      tbl[3] = '{data: 8'h81, pat: 10'b1100000010};
      tbl[4] = '{data: 8'h3C, pat: 10'b1001111000};

      // Reset held for 5 cycles, then idle without requests.
      errs  = 0;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) errs++;
         if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) errs++;
      end
      check("reset_hold", errs, 0);
      reset = 1'b1;
      errs  = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) errs++;
         if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) errs++;
      end
      check("idle_no_start", errs, 0);

      sel = 1'b0;
      for (int i = 0; i < 5; i++) begin
         frame("table", tbl[i].data, 2, 16, 1'b0, -10, 8'h00, mid);
         check("table bit_pattern", int'(mid), int'(tbl[i].pat));
      end

      frame("b2b_first", 8'h00, 2, 16, 1'b1, -10, 8'h00, mid);
      frame("b2b_second", 8'hFF, 2, 16, 1'b0, -10, 8'h00, mid);

      frame("ignore_mid", 8'h81, 2, 16, 1'b0, 16 * 2 * 4 + 5, 8'h3C, mid);
      frame("ignore_done_cycle", 8'h5A, 2, 16, 1'b0, 320, 8'hC3, mid);

      // Reset during data bit 5 of a 0x00 frame, where the line would otherwise be low.
      drive(1'b1, 8'h00);
      tick();
      drive(1'b0, 8'hFF);
      for (int c = 1; c < 16 * 2 * 6 + 10; c++) tick();
      check("pre_reset_low", int'(tx_a), 0);
      reset = 1'b0;
      tick();
      check("reset_mid tx", int'(tx_a), 1);
      check("reset_mid busy", int'(busy_a), 0);
      check("reset_mid done", int'(done_a), 0);
      reset = 1'b1;
      errs  = 0;
      for (int i = 0; i < 400; i++) begin
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) errs++;
         tick();
      end
      check("reset_mid quiet", errs, 0);
      frame("reset_recover", 8'h55, 2, 16, 1'b0, -10, 8'h00, mid);
      check("reset_recover bit_pattern", int'(mid), int'(10'b1010101010));

      for (int i = 0; i < 6; i++) begin
         rd = 8'($urandom);
         frame("rand_a", rd, 2, 16, (i < 5) ? 1'($urandom) : 1'b0,
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 320)) : -10,
               8'($urandom), mid);
         check("rand_a bit_pattern", int'(mid), int'({1'b1, rd, 1'b0}));
      end

      sel = 1'b1;
      frame("two_stop", 8'h0F, 1, 32, 1'b0, -10, 8'h00, mid);
      check("two_stop bit_pattern", int'(mid), int'(10'b1000011110));
      for (int i = 0; i < 3; i++) begin
         rd = 8'($urandom);
         frame("rand_b", rd, 1, 32, 1'b0, int'($urandom_range(1, 176)), 8'($urandom), mid);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
